// File: rtl/wb_heartbeat_pkg.sv
// ---------------------------------------------------------------------------
// wb_heartbeat_pkg
// Shared definitions for the Wishbone heartbeat register block:
//   - register word indices (CTRL, DIV, COUNT, STATUS)
//   - CTRL / STATUS bit positions
//   - prescaler divider and beat counter widths
//   - bus handshake state encoding
//   - byte-lane merge helper used for DIV writes
// ---------------------------------------------------------------------------
package wb_heartbeat_pkg;

    localparam int DIV_W   = 16;
    localparam int COUNT_W = 8;

    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_DIV    = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int CTRL_CLR_BIT    = 2;
    localparam int STATUS_WRAP_BIT = 0;

    // BUS_ACK is the single cycle during which wbs_ack_o is high.
    typedef enum logic {
        BUS_IDLE = 1'b0,
        BUS_ACK  = 1'b1
    } bus_state_t;

    // Replace the bytes of cur whose lane enable is set.
    function automatic logic [DIV_W-1:0] merge_lanes(
        input logic [DIV_W-1:0] cur,
        input logic [DIV_W-1:0] wdata,
        input logic [1:0]       lanes
    );
        logic [DIV_W-1:0] res;
        res = cur;
        for (int b = 0; b < 2; b++) begin
            if (lanes[b]) begin
                res[b*8 +: 8] = wdata[b*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/wb_heartbeat_regs_prescaler.sv
// ---------------------------------------------------------------------------
// heartbeat_prescaler
// Programmable tick generator. While en is high the internal presc register
// counts 0..div and emits a one-cycle tick on the cycle presc >= div, giving
// a tick period of div+1 cycles (div=0 ticks every cycle). While en is low
// presc holds. clr zeroes presc and suppresses the tick of that cycle.
//
// Ports:
//   clk   in   clock
//   rst   in   asynchronous active-high reset
//   en    in   advance enable
//   clr   in   synchronous clear of presc (wins over a due tick)
//   div   in   divider value [DIV_W-1:0]
//   tick  out  one-cycle pulse, combinational from presc/en/clr/div
// ---------------------------------------------------------------------------
module heartbeat_prescaler
    import wb_heartbeat_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] presc_reg;
    logic             due;

    // ">=" rather than "==" so that lowering DIV below the running presc
    // fires on the next enabled cycle instead of waiting for a 16-bit wrap.
    assign due  = (presc_reg >= div);
    assign tick = en & ~clr & due;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_reg <= '0;
        end else if (clr) begin
            presc_reg <= '0;
        end else if (en) begin
            if (due) begin
                presc_reg <= '0;
            end else begin
                presc_reg <= presc_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_heartbeat_regs.sv
// ---------------------------------------------------------------------------
// wb_heartbeat_regs
// Wishbone-classic register slave controlling a programmable heartbeat.
//
// Register map (word index = wbs_adr_i[3:2]):
//   0x0 CTRL   bit0 EN, bit1 IRQ_EN, bit2 CLR (write-only pulse, reads 0)
//   0x4 DIV    [15:0] prescaler divider, tick period DIV+1 cycles
//   0x8 COUNT  [7:0]  beat counter, read-only
//   0xC STATUS bit0 WRAP, sticky, write-1-to-clear
//
// Ports:
//   wb_clk_i     in   clock
//   wb_rst_i     in   asynchronous active-high reset
//   wbs_stb_i    in   strobe
//   wbs_cyc_i    in   cycle
//   wbs_we_i     in   write enable
//   wbs_sel_i    in   byte lanes [3:0] (only [1:0] are used)
//   wbs_dat_i    in   write data [31:0]
//   wbs_adr_i    in   byte address [31:0]
//   wbs_ack_o    out  registered one-cycle acknowledge
//   wbs_dat_o    out  registered read data, zero outside read acks
//   beat_o       out  count[7]
//   irq_o        out  WRAP & IRQ_EN
//   la_data_out  out  logic-analyzer mirror of count
//
// Build option: define WB_HEARTBEAT_LA_MIRROR_EN to drive la_data_out from
// the beat counter; otherwise la_data_out is tied to zero.
// ---------------------------------------------------------------------------
module wb_heartbeat_regs
    import wb_heartbeat_pkg::*;
#(
    parameter logic [31:0]      BASE_ADDR = 32'h3000_0000,
    parameter logic [DIV_W-1:0] DIV_RESET = 16'hFFFF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        beat_o,
    output logic        irq_o,
    output logic [7:0]  la_data_out
);

    // ------------------------------------------------------------------
    // Bus handshake
    // ------------------------------------------------------------------
    bus_state_t bus_state_reg;
    bus_state_t bus_state_next;
    logic       sel_hit;
    logic       req;
    logic       wr;
    logic       rd;
    logic [1:0] idx;

    assign sel_hit = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign idx     = wbs_adr_i[3:2];

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            bus_state_reg <= BUS_IDLE;
        end else begin
            bus_state_reg <= bus_state_next;
        end
    end

    // A request is only accepted from IDLE, so a held strobe alternates
    // IDLE/ACK and is acknowledged every second cycle.
    always_comb begin
        bus_state_next = BUS_IDLE;
        req            = 1'b0;
        case (bus_state_reg)
            BUS_IDLE: begin
                if (wbs_stb_i && wbs_cyc_i && sel_hit) begin
                    req            = 1'b1;
                    bus_state_next = BUS_ACK;
                end
            end
            BUS_ACK: begin
                bus_state_next = BUS_IDLE;
            end
            default: begin
                bus_state_next = BUS_IDLE;
            end
        endcase
    end

    assign wbs_ack_o = (bus_state_reg == BUS_ACK);
    assign wr        = req & wbs_we_i;
    assign rd        = req & ~wbs_we_i;

    // ------------------------------------------------------------------
    // Register writes (commit on the edge that raises ack)
    // ------------------------------------------------------------------
    logic             en_reg;
    logic             irq_en_reg;
    logic [DIV_W-1:0] div_reg;
    logic             wr_ctrl;
    logic             wr_div;
    logic             wr_status;
    logic             clr;
    logic             w1c_wrap;

    assign wr_ctrl   = wr && (idx == REG_CTRL);
    assign wr_div    = wr && (idx == REG_DIV);
    assign wr_status = wr && (idx == REG_STATUS);
    assign clr       = wr_ctrl & wbs_sel_i[0] & wbs_dat_i[CTRL_CLR_BIT];
    assign w1c_wrap  = wr_status & wbs_sel_i[0] & wbs_dat_i[STATUS_WRAP_BIT];

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            en_reg     <= 1'b0;
            irq_en_reg <= 1'b0;
            div_reg    <= DIV_RESET;
        end else begin
            if (wr_ctrl && wbs_sel_i[0]) begin
                en_reg     <= wbs_dat_i[CTRL_EN_BIT];
                irq_en_reg <= wbs_dat_i[CTRL_IRQ_EN_BIT];
            end
            if (wr_div) begin
                div_reg <= merge_lanes(div_reg, wbs_dat_i[DIV_W-1:0], wbs_sel_i[1:0]);
            end
        end
    end

    // ------------------------------------------------------------------
    // Prescaler and beat counter
    // ------------------------------------------------------------------
    logic               tick;
    logic [COUNT_W-1:0] count_reg;
    logic               wrap_reg;

    // The prescaler sees the EN value from before a concurrent CTRL write,
    // so enabling takes effect from the cycle after the ack edge.
    heartbeat_prescaler u_prescaler (
        .clk  (wb_clk_i),
        .rst  (wb_rst_i),
        .en   (en_reg),
        .clr  (clr),
        .div  (div_reg),
        .tick (tick)
    );

    // tick is already masked by clr, so a CLR on a due cycle leaves count 0.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (tick) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // Setting has priority over a same-cycle write-1-to-clear.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wrap_reg <= 1'b0;
        end else if (tick && (count_reg == COUNT_MAX)) begin
            wrap_reg <= 1'b1;
        end else if (w1c_wrap) begin
            wrap_reg <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Read path: data is valid only in the ack cycle
    // ------------------------------------------------------------------
    logic [31:0] rd_mux;
    logic [31:0] dat_reg;

    always_comb begin
        rd_mux = '0;
        case (idx)
            REG_CTRL: begin
                rd_mux[CTRL_EN_BIT]     = en_reg;
                rd_mux[CTRL_IRQ_EN_BIT] = irq_en_reg;
            end
            REG_DIV:    rd_mux[DIV_W-1:0]       = div_reg;
            REG_COUNT:  rd_mux[COUNT_W-1:0]     = count_reg;
            REG_STATUS: rd_mux[STATUS_WRAP_BIT] = wrap_reg;
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            dat_reg <= '0;
        end else if (rd) begin
            dat_reg <= rd_mux;
        end else begin
            dat_reg <= '0;
        end
    end

    assign wbs_dat_o = dat_reg;

    // ------------------------------------------------------------------
    // Outputs taken straight from register outputs
    // ------------------------------------------------------------------
    assign beat_o = count_reg[COUNT_W-1];
    assign irq_o  = wrap_reg & irq_en_reg;

`ifdef WB_HEARTBEAT_LA_MIRROR_EN
    assign la_data_out = count_reg;
`else
    assign la_data_out = 8'h00;
`endif

    // Address bits below the word index, upper data bits and the upper
    // byte lanes carry no meaning for this block.
    logic unused_inputs;
    assign unused_inputs = ^{wbs_adr_i[1:0], wbs_sel_i[3:2], wbs_dat_i[31:DIV_W]};

endmodule

// File: doc/wb_heartbeat_regs.md
# wb_heartbeat_regs

Wishbone-classic register slave for the user project area, driven directly by the wrapper's `wbs_*` port group. It gives firmware control of a programmable heartbeat: an enable, a 16-bit tick prescaler and a readable 8-bit beat counter. It produces the beat output for a GPIO pin and a wrap interrupt for `user_irq`.

## Interface
- `BASE_ADDR`, default 32'h3000_0000: decode base; bits [3:0] must be zero.
- `DIV_RESET`, default 16'hFFFF: reset value of DIV.
- `wb_clk_i` input, 1 bit: single clock; all state is on its rising edge.
- `wb_rst_i` input, 1 bit: reset, asynchronous, active-high.
- `wbs_stb_i` input, 1 bit: Wishbone strobe.
- `wbs_cyc_i` input, 1 bit: Wishbone cycle.
- `wbs_we_i` input, 1 bit: write enable.
- `wbs_sel_i` input, 4 bits: byte lane selects.
- `wbs_dat_i` input, 32 bits: write data.
- `wbs_adr_i` input, 32 bits: byte address.
- `wbs_ack_o` output, 1 bit: acknowledge.
- `wbs_dat_o` output, 32 bits: read data.
- `beat_o` output, 1 bit: heartbeat, equal to count[7].
- `irq_o` output, 1 bit: wrap interrupt.
- `la_data_out` output, 8 bits: logic-analyzer mirror (see Configuration).

## Operation
- Decode: the block is selected when `wbs_adr_i[31:4] == BASE_ADDR[31:4]`. The word index is `wbs_adr_i[3:2]`.
- Registers:
  - 0x0 CTRL: bit0 EN, bit1 IRQ_EN, bit2 CLR. CLR is write-only and self-clearing; it always reads 0.
  - 0x4 DIV: [15:0].
  - 0x8 COUNT: [7:0], read-only.
  - 0xC STATUS: bit0 WRAP, sticky, write-1-to-clear.
- Unused bits read 0. Writes honour `wbs_sel_i[0]` for bits [7:0] and `wbs_sel_i[1]` for bits [15:8]; `sel[3:2]` are ignored.
- Prescaler (16 bits): advances only while EN=1.
  - If `presc >= DIV`: presc←0 and tick=1.
  - Otherwise: presc←presc+1.
  - DIV=0 gives a tick every cycle. The tick period is DIV+1 cycles.
- Counter (8 bits): increments on each tick and wraps from 255 to 0. The 255→0 transition sets WRAP.
- While EN=0, the prescaler and counter hold their values.
- CLR write: presc←0 and count←0 on the ack edge. WRAP is unaffected.
- `irq_o` = WRAP & IRQ_EN, combinational from registers.
- Simultaneous events:
  - CLR and tick in the same cycle: CLR wins, and count stays 0.
  - WRAP set and a W1C in the same cycle: set wins.
  - DIV written below the current presc: the `>=` compare fires on the next enabled cycle.
- Unselected or unmapped addresses: no ack is generated. The bus default slave handles them.

## Timing
- Reset values:
  - `wbs_ack_o`=0, `wbs_dat_o`=0.
  - EN=0, IRQ_EN=0, DIV=DIV_RESET, presc=0, count=0, WRAP=0.
  - `beat_o`=0, `irq_o`=0, `la_data_out`=0.
- Ack:
  - Registered: `ack ← stb & cyc & sel_hit & !ack`.
  - It is exactly one cycle wide, one cycle after the request is seen.
  - A held strobe therefore produces an ack every second cycle.
- Writes commit on the same edge that raises ack.
- Reads: `wbs_dat_o` is registered in the same cycle as ack and returns to 0 the cycle after.
- A COUNT read returns the value before the concurrent edge.
- `beat_o` and `la_data_out` follow count with zero added latency, because they are taken from the register output.
- Reset asserted mid-transfer: ack drops immediately (asynchronously) and no write commits.

## Configuration
- `WB_HEARTBEAT_LA_MIRROR_EN`
  - Defined: `la_data_out` = count[7:0].
  - Undefined: `la_data_out` is tied to 8'h00 and no mirror logic is built.

## Structure
- Package `wb_heartbeat_pkg` holds:
  - register word indices (CTRL=0, DIV=1, COUNT=2, STATUS=3);
  - CTRL and STATUS bit positions;
  - the DIV and COUNT widths.
- One sub-module, `heartbeat_prescaler`. Inputs: clk, rst, en, clr, div. Output: a tick pulse. It contains the presc register and the compare logic.
- The top level holds the bus FSM, the registers and the counter.

## Test plan
- Reset, then read all four registers: CTRL=0, DIV=0xFFFF, COUNT=0, STATUS=0. Each ack is one cycle wide, one cycle after the strobe.
- Write DIV=3, then CTRL=1, and run 40 cycles: COUNT=10 (±1 depending on the write edge), with ticks exactly every 4 cycles.
- DIV=0, EN=1, IRQ_EN=1, run 256 cycles: COUNT wraps to 0, WRAP=1, `irq_o`=1. Writing STATUS=1 clears both on the ack edge.
- Write CTRL=0x5 on the cycle a tick is due: COUNT reads 0. Repeat with `wbs_sel_i`=4'b0000: no change, but ack is still returned.
- Hold `wbs_stb_i`/`wbs_cyc_i` high for 6 cycles: exactly 3 acks. An access at `BASE_ADDR`+0x10: no ack.
- Assert `wb_rst_i` during a DIV write's request cycle: ack never rises and DIV stays 0xFFFF. With the macro defined, `la_data_out` tracks COUNT; without it, `la_data_out` stays 0.
